// File: rtl/painel_pkg.sv
// Shared types and default timing for the LED panel scan/scroll logic.
package painel_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } estado_t;

    localparam int DEF_SCAN_DIV        = 8;
    localparam int DEF_BLANK_CYC       = 2;
    localparam int DEF_ROWS            = 7;
    localparam int DEF_FRAMES_PER_STEP = 64;
    localparam int DEF_MSG_LEN         = 16;

    localparam int DEF_SLOT_W  = $clog2(DEF_SCAN_DIV);
    localparam int DEF_ROW_W   = $clog2(DEF_ROWS);
    localparam int DEF_FRAME_W = $clog2(DEF_FRAMES_PER_STEP);
    localparam int DEF_COL_W   = $clog2(DEF_MSG_LEN);

endpackage

// File: rtl/gerador_tick.sv
// Modulo-N enable counter; wrap flags the enabled cycle that returns cnt to 0.
module gerador_tick #(
    parameter int N = 8,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = en && (cnt == W'(N - 1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/controlador_varredura_painel.sv
// Row strobe sequencer with per-row blanking and frame-counted text scroll.
module controlador_varredura_painel
    import painel_pkg::*;
#(
    parameter int SCAN_DIV        = DEF_SCAN_DIV,
    parameter int BLANK_CYC       = DEF_BLANK_CYC,
    parameter int ROWS            = DEF_ROWS,
    parameter int FRAMES_PER_STEP = DEF_FRAMES_PER_STEP,
    parameter int MSG_LEN         = DEF_MSG_LEN
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       scroll_en,
    input  logic [1:0]                 speed,
    output logic [ROWS-1:0]            row_sel,
    output logic [$clog2(ROWS)-1:0]    row_idx,
    output logic [$clog2(MSG_LEN)-1:0] col_offset,
    output logic                       frame_start,
    output logic                       busy
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int RW = $clog2(ROWS);
    localparam int FW = $clog2(FRAMES_PER_STEP);
    localparam int CW = $clog2(MSG_LEN);

    estado_t       estado, estado_n;
    logic [SW-1:0] slot_cnt;
    logic          slot_wrap;
    logic          row_wrap;
    logic          cnt_clr;
    logic          frame_end;
    logic [FW-1:0] frame_cnt;
    logic [FW-1:0] limiar;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= IDLE;
        end else begin
            estado <= estado_n;
        end
    end

    // stop outranks start, so a simultaneous pulse in IDLE stays in IDLE
    always_comb begin
        estado_n = estado;
        case (estado)
            IDLE:    if (start && !stop) estado_n = SCAN;
            SCAN:    if (stop)           estado_n = IDLE;
            default: estado_n = IDLE;
        endcase
    end

    // Counters sit at zero whenever idle, so the start edge begins at row 0 slot 0
    assign cnt_clr = stop || (estado == IDLE);

    gerador_tick #(.N(SCAN_DIV), .W(SW)) u_slot (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (estado == SCAN),
        .cnt   (slot_cnt),
        .wrap  (slot_wrap)
    );

    gerador_tick #(.N(ROWS), .W(RW)) u_row (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (slot_wrap),
        .cnt   (row_idx),
        .wrap  (row_wrap)
    );

    assign busy        = (estado == SCAN);
    assign frame_start = busy && (slot_cnt == '0) && (row_idx == '0);
    assign row_sel     = (busy && (slot_cnt >= SW'(BLANK_CYC))) ? (ROWS'(1) << row_idx) : '0;

    assign frame_end = row_wrap && !stop;
    assign limiar    = FW'((FRAMES_PER_STEP >> speed) - 1);

    // >= lets a mid-count speed-up step at the next frame end instead of stalling
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt  <= '0;
            col_offset <= '0;
        end else if (estado == IDLE) begin
            if (start && !stop) frame_cnt <= '0;
        end else if (frame_end) begin
            if (!scroll_en) begin
                frame_cnt <= '0;
            end else if (frame_cnt >= limiar) begin
                frame_cnt  <= '0;
                col_offset <= (col_offset == CW'(MSG_LEN - 1)) ? '0 : col_offset + 1'b1;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/controlador_varredura_painel.md
Name: controlador_varredura_painel

Overview:
Scan and scroll controller for the multiplexed LED display panel. It replaces ripple-clock division with single-clock enable ticks. It sequences row strobing, with a blanking interval per row to prevent ghosting, and advances the text scroll offset every N complete frames. It sits between the system clock and the panel row drivers and character ROM addressing.

Parameters:
SCAN_DIV, 8, clk cycles per row slot; must be > BLANK_CYC
BLANK_CYC, 2, cycles at the start of each slot with all rows off; must be >= 1
ROWS, 7, number of panel rows
FRAMES_PER_STEP, 64, frames per scroll step at speed 0; power of 2, >= 8
MSG_LEN, 16, scroll positions; col_offset wraps at MSG_LEN

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse: begin scanning
stop  in  1  one-cycle pulse: halt and blank
scroll_en  in  1  level: allow col_offset to advance
speed  in  2  scroll threshold = FRAMES_PER_STEP >> speed
row_sel  out  ROWS  one-hot row drive, active-high; all-zero while blanking or idle
row_idx  out  $clog2(ROWS)  current row index
col_offset  out  $clog2(MSG_LEN)  current scroll position
frame_start  out  1  one-cycle pulse at slot 0 of row 0
busy  out  1  high while in SCAN

Behaviour:
- Single clock domain. All state updates on posedge clk. Reset is synchronous, active-high, and has priority over every other input.
- Reset values: state=IDLE, slot_cnt=0, row_idx=0, frame_cnt=0, col_offset=0, row_sel=0, frame_start=0, busy=0.
- FSM has two states, IDLE and SCAN.
  - IDLE + start -> SCAN. The same edge clears slot_cnt, row_idx and frame_cnt. col_offset is kept.
  - SCAN + stop -> IDLE on the next edge. row_sel=0 from that edge onward. row_idx and slot_cnt are cleared.
  - start and stop in the same cycle: stop wins. In IDLE this means the block stays in IDLE.
  - start while in SCAN is ignored. stop while in IDLE is ignored.
- Slot counter (SCAN only):
  - slot_cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - On wrap, row_idx increments modulo ROWS (ROWS-1 -> 0).
- Row drive:
  - row_sel[row_idx]=1 iff state==SCAN and slot_cnt>=BLANK_CYC. Otherwise row_sel=0.
  - Outputs are registered and decoded from the current registers, so row_sel and row_idx never change in the same cycle as a different row becomes active.
- frame_start=1 iff state==SCAN and slot_cnt==0 and row_idx==0. It is high in the first SCAN cycle after start.
- Frame end is the cycle where slot_cnt==SCAN_DIV-1 and row_idx==ROWS-1. At frame end:
  - If scroll_en=0: frame_cnt is cleared and col_offset is held.
  - Else if frame_cnt >= (FRAMES_PER_STEP>>speed)-1: frame_cnt is cleared and col_offset = (col_offset==MSG_LEN-1) ? 0 : col_offset+1.
  - Else: frame_cnt increments.
- The >= compare means a speed increase mid-count steps at the next frame end and never stalls.
- busy = (state==SCAN).
- Reset mid-scan: all outputs return to reset values on the reset edge. This includes col_offset.
- Frame period is SCAN_DIV*ROWS cycles. Row duty cycle is (SCAN_DIV-BLANK_CYC)/SCAN_DIV.

Decomposition:
- Package painel_pkg holds:
  - the state enum {IDLE, SCAN};
  - width helper constants derived with $clog2;
  - the default timing constants (SCAN_DIV, BLANK_CYC, FRAMES_PER_STEP) shared with the panel top level.
- Sub-module gerador_tick is a parameterised modulo-N enable counter with inputs clk, reset, clr, en and outputs cnt, wrap.
  - It is instantiated twice: as the slot counter (N=SCAN_DIV) and as the row counter, which is enabled by the slot counter's wrap.
  - The frame/scroll logic stays in the top module.

Test Plan:
All scenarios use SCAN_DIV=8, BLANK_CYC=2, ROWS=4, FRAMES_PER_STEP=8, MSG_LEN=3.
1. Reset, then a start pulse at cycle t -> busy=1 and frame_start=1 at t+1. row_sel=0000 for t+1..t+2, row_sel=0001 for t+3..t+8, row_sel=0000 at t+9..t+10, row_sel=0010 from t+11.
2. Free run with scroll_en=0 for 200 cycles -> frame_start every 32 cycles. row_sel is always one-hot or zero. col_offset stays at 0.
3. scroll_en=1, speed=0 -> col_offset goes 0->1 after 8 frames (256 cycles), 1->2 after 16 frames, 2->0 after 24 frames (wrap). With speed=2 -> one step every 2 frames.
4. speed changed 0->3 when frame_cnt=5 -> col_offset steps at the very next frame end, and frame_cnt then restarts from 0.
5. stop issued mid-row (slot_cnt=4, row_idx=2) -> row_sel=0 and busy=0 on the next edge. A new start resumes at row 0 with col_offset preserved. start and stop in the same cycle while in IDLE -> the block stays in IDLE.
6. reset asserted mid-frame with col_offset=2 -> on the next edge all outputs are 0 and state=IDLE. A start issued while reset is high is ignored.
